// File: rtl/shape_display_scheduler.sv
// Chooses which shape-object layer drives the VGA pixel, from debounced next/prev
// buttons or a frame-based auto-cycle, committing changes only at vertical blank.
module shape_display_scheduler #(
    parameter int NUM_OBJ     = 4,
    parameter int SEL_W       = 2,
    parameter int DEB_CYCLES  = 500000,
    parameter int AUTO_FRAMES = 120,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter logic [8*NUM_OBJ-1:0] OBJ_COLORS = 32'hE0_1C_03_FF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               auto_en,
    input  logic [9:0]         HCount,
    input  logic [9:0]         VCount,
    input  logic [NUM_OBJ-1:0] obj_on,
    output logic [SEL_W-1:0]   sel,
    output logic               pending,
    output logic               pixel_on,
    output logic [7:0]         rgb
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int FR_W  = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [FR_W-1:0]  AUTO_LAST = FR_W'(AUTO_FRAMES - 1);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_OBJ - 1);
    localparam logic [9:0]       H_LIM     = 10'(H_ACTIVE);
    localparam logic [9:0]       V_LIM     = 10'(V_ACTIVE);

    typedef enum logic {IDLE, PEND} state_t;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] x);
        return (x >= SEL_MAX) ? '0 : x + SEL_W'(1);
    endfunction

    function automatic logic [SEL_W-1:0] wrap_dec(input logic [SEL_W-1:0] x);
        return (x == '0) ? SEL_MAX : x - SEL_W'(1);
    endfunction

    // Bit 0 is the next button, bit 1 the prev button.
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             at_vb_q, at_vb_d;
    logic [FR_W-1:0]  frame_q, frame_d;
    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, target_q, target_d;
    logic             pixel_on_q, pixel_on_d;
    logic [7:0]       rgb_q, rgb_d;

    logic [1:0]           press;
    logic                 inc, dec, vb_tick;
    logic [SEL_W-1:0]     target_adj;
    logic [2**SEL_W-1:0]  obj_pad;
    logic [7:0]           color;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        sync1_d    = {btn_prev, btn_next};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == DEB_LAST) deb_d[b] = sync2_q[b];
                else                      cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
        press = deb_q & ~deb_prev_q;
        // Opposite presses in the same cycle cancel out.
        inc   = press[0] & ~press[1];
        dec   = press[1] & ~press[0];

        // Edge-detect the blank position so a count held for several clocks ticks once.
        at_vb_d = (HCount == 10'd0) && (VCount == V_LIM);
        vb_tick = at_vb_d && !at_vb_q;

        target_adj = inc ? wrap_inc(target_q) : (dec ? wrap_dec(target_q) : target_q);

        state_d  = state_q;
        sel_d    = sel_q;
        target_d = target_q;
        frame_d  = auto_en ? frame_q : '0;
        if (auto_en && vb_tick) frame_d = frame_q + FR_W'(1);

        case (state_q)
            IDLE: begin
                if (inc) begin
                    target_d = wrap_inc(sel_q);
                    state_d  = PEND;
                end else if (dec) begin
                    target_d = wrap_dec(sel_q);
                    state_d  = PEND;
                end else if (auto_en && vb_tick && frame_q >= AUTO_LAST) begin
                    sel_d   = wrap_inc(sel_q);
                    frame_d = '0;
                end
            end
            PEND: begin
                target_d = target_adj;
                if (vb_tick) begin
                    sel_d   = target_adj;
                    state_d = IDLE;
                    frame_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        obj_pad = '0;
        color   = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            obj_pad[i] = obj_on[i];
            if (int'(sel_q) == i) color = OBJ_COLORS[8*i +: 8];
        end
        pixel_on_d = (int'(sel_q) < NUM_OBJ) && obj_pad[sel_q]
                     && (HCount < H_LIM) && (VCount < V_LIM);
        rgb_d      = pixel_on_d ? color : 8'h00;
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '{default: '0};
            at_vb_q    <= 1'b0;
            frame_q    <= '0;
            state_q    <= IDLE;
            sel_q      <= '0;
            target_q   <= '0;
            pixel_on_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
            at_vb_q    <= at_vb_d;
            frame_q    <= frame_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            target_q   <= target_d;
            pixel_on_q <= pixel_on_d;
            rgb_q      <= rgb_d;
        end
    end

    assign sel      = sel_q;
    assign pending  = (state_q == PEND);
    assign pixel_on = pixel_on_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_shape_display_scheduler.sv
// Directed bench for shape_display_scheduler with short debounce and a two-frame auto period.
module tb_shape_display_scheduler;

    localparam int DEB  = 8;
    localparam int AUTO = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next, btn_prev, auto_en;
    logic [9:0] HCount, VCount;
    logic [3:0] obj_on;
    logic [1:0] sel;
    logic       pending, pixel_on;
    logic [7:0] rgb;

    int vec_cnt = 0;
    int err_cnt = 0;

    shape_display_scheduler #(
        .NUM_OBJ(4), .SEL_W(2), .DEB_CYCLES(DEB), .AUTO_FRAMES(AUTO),
        .H_ACTIVE(640), .V_ACTIVE(480), .OBJ_COLORS(32'hE0_1C_03_FF)
    ) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .auto_en(auto_en), .HCount(HCount), .VCount(VCount), .obj_on(obj_on),
        .sel(sel), .pending(pending), .pixel_on(pixel_on), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic nxt, input logic prv);
        btn_next = nxt;
        btn_prev = prv;
        tick(DEB + 4);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(DEB + 4);
    endtask

    task automatic vblank();
        HCount = 10'd0;
        VCount = 10'd480;
        tick(1);
        VCount = 10'd100;
        tick(1);
    endtask

    int lat;

    initial begin
        reset    = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        auto_en  = 1'b0;
        HCount   = 10'd0;
        VCount   = 10'd100;
        obj_on   = 4'b0000;
        tick(3);
        reset = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            tick(1);
            check("reset_idle", {sel, pending, pixel_on, rgb}, 32'h0);
        end

        // Raw edge to pending: 2 sync stages + DEB stable samples + 1 FSM cycle.
        btn_next = 1'b1;
        lat = 0;
        for (int i = 1; i <= DEB + 3; i++) begin
            tick(1);
            if (pending) begin
                lat = i;
                break;
            end
        end
        check("next_latency", lat, DEB + 3);
        btn_next = 1'b0;
        tick(DEB + 4);
        check("next_wait_sel", sel, 0);
        check("next_wait_pend", pending, 1);
        vblank();
        check("next_commit_sel", sel, 1);
        check("next_commit_pend", pending, 0);

        btn_next = 1'b1;
        tick(DEB - 1);
        btn_next = 1'b0;
        tick(2 * DEB);
        check("bounce_pend", pending, 0);
        check("bounce_sel", sel, 1);

        press(1'b0, 1'b1);
        vblank();
        check("prev_1_to_0", sel, 0);
        press(1'b0, 1'b1);
        check("prev_pend", pending, 1);
        vblank();
        check("prev_wrap_0_to_3", sel, 3);
        press(1'b1, 1'b0);
        vblank();
        check("next_wrap_3_to_0", sel, 0);

        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        vblank();
        check("accum_0_to_2", sel, 2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        vblank();
        check("accum_wrap_2_to_0", sel, 0);

        press(1'b1, 1'b1);
        check("both_pend", pending, 0);
        vblank();
        check("both_sel", sel, 0);

        auto_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            vblank();
            check($sformatf("auto_tick%0d", k), sel, (k / 2) % 4);
        end
        // Counter at 1 here; a pending button commit must win over the auto advance.
        vblank();
        check("auto_pre_sel", sel, 0);
        press(1'b1, 1'b0);
        vblank();
        check("btn_beats_auto", sel, 1);
        vblank();
        check("frame_reset_on_commit", sel, 1);
        auto_en = 1'b0;
        vblank();
        vblank();
        check("auto_off_hold", sel, 1);

        // Object 1 colour is bits [15:8] = 8'h03.
        obj_on = 4'b0010;
        HCount = 10'd10;
        VCount = 10'd10;
        tick(1);
        check("pix_on_sel1", pixel_on, 1);
        check("rgb_sel1", rgb, 8'h03);
        HCount = 10'd700;
        tick(1);
        check("pix_off_h700", pixel_on, 0);
        check("rgb_off_h700", rgb, 8'h00);
        HCount = 10'd10;
        VCount = 10'd480;
        tick(1);
        check("pix_off_v480", {pixel_on, rgb}, 0);
        VCount = 10'd10;
        obj_on = 4'b1101;
        tick(1);
        check("pix_other_objs", {pixel_on, rgb}, 0);

        HCount = 10'd0;
        VCount = 10'd100;
        press(1'b1, 1'b0);
        vblank();
        check("sel_2", sel, 2);
        obj_on = 4'b0100;
        HCount = 10'd639;
        VCount = 10'd479;
        tick(1);
        check("pix_sel2_corner", {pixel_on, rgb}, {1'b1, 8'h1C});

        HCount = 10'd0;
        VCount = 10'd100;
        press(1'b1, 1'b0);
        check("pre_reset_pend", pending, 1);
        reset = 1'b1;
        #1;
        check("async_reset", {sel, pending, pixel_on, rgb}, 0);
        tick(2);
        reset = 1'b0;
        vblank();
        check("reset_drops_pend", {sel, pending}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
